// File: rtl/sram_req_arbiter_pkg.sv
// Shared types for the inst/data SRAM-like arbiter: source IDs and the forwarded command bundle.
// Combinational helpers only; no latency or backpressure of its own.
`ifndef W_ADDR
`define W_ADDR 32
`endif
`ifndef W_DATA
`define W_DATA 32
`endif

package sram_req_arbiter_pkg;

  localparam int ADDR_W = `W_ADDR;
  localparam int DATA_W = `W_DATA;
  localparam int SIZE_W = 2;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } req_src_t;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_cmd_t;

  function automatic req_src_t other_src(input req_src_t s);
    return (s == SRC_INST) ? SRC_DATA : SRC_INST;
  endfunction

endpackage

// File: rtl/sram_id_fifo.sv
// In-order owner-ID FIFO: one entry per accepted-but-uncompleted transaction, head read combinationally.
// Push/pop take effect on the next edge; push while full and pop while empty are ignored.
module sram_id_fifo
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  logic     pop_i,
  input  req_src_t din_i,
  output req_src_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  req_src_t        mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= SRC_INST;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
      end
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Muxes inst/data SRAM-like channels onto one port; addr_ok/data_ok/rdata route back with zero latency.
// Grant is held until addr_ok; no request is forwarded while DEPTH transactions are outstanding.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int RR_MODE = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [SIZE_W-1:0] inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [SIZE_W-1:0] m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  req_src_t  grant;
  req_src_t  owner_q, owner_d;
  req_src_t  rr_last_q, rr_last_d;
  logic      lock_q, lock_d;
  logic      err_q, err_d;

  sram_cmd_t inst_cmd, data_cmd, sel_cmd;
  logic      granted_req;
  logic      accept;
  logic      pop;
  logic      spurious;
  logic      fifo_full, fifo_empty;
  req_src_t  fifo_head;

  assign inst_cmd = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
  assign data_cmd = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

  // A locked owner keeps the port even if the other side now wins arbitration.
  always_comb begin
    grant = SRC_INST;
    if (lock_q) begin
      grant = owner_q;
    end else if (RR_MODE == 0) begin
      grant = data_req ? SRC_DATA : SRC_INST;
    end else if (inst_req && data_req) begin
      grant = other_src(rr_last_q);
    end else begin
      grant = data_req ? SRC_DATA : SRC_INST;
    end
  end

  assign granted_req = (grant == SRC_DATA) ? data_req : inst_req;

  // Gating with resetn keeps the downstream port quiet while reset is held.
  assign m_req   = granted_req & ~fifo_full & resetn;
  assign sel_cmd = !m_req ? '0 : ((grant == SRC_DATA) ? data_cmd : inst_cmd);
  assign m_wr    = sel_cmd.wr;
  assign m_size  = sel_cmd.size;
  assign m_addr  = sel_cmd.addr;
  assign m_wdata = sel_cmd.wdata;

  assign accept       = m_req & m_addr_ok;
  assign inst_addr_ok = accept & (grant == SRC_INST);
  assign data_addr_ok = accept & (grant == SRC_DATA);

  assign pop          = m_data_ok & ~fifo_empty & resetn;
  assign spurious     = m_data_ok & fifo_empty;
  assign inst_data_ok = pop & (fifo_head == SRC_INST);
  assign data_data_ok = pop & (fifo_head == SRC_DATA);
  assign inst_rdata   = inst_data_ok ? m_rdata : '0;
  assign data_rdata   = data_data_ok ? m_rdata : '0;
  assign err          = err_q;

  always_comb begin
    lock_d    = m_req & ~m_addr_ok;
    owner_d   = lock_d ? grant : owner_q;
    rr_last_d = accept ? grant : rr_last_q;
    err_d     = err_q | spurious;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q    <= 1'b0;
      owner_q   <= SRC_INST;
      rr_last_q <= SRC_INST;
      err_q     <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      err_q     <= err_d;
    end
  end

  sram_id_fifo #(
    .DEPTH(DEPTH)
  ) u_id_fifo (
    .clk    (clk),
    .rst_n  (resetn),
    .push_i (accept),
    .pop_i  (pop),
    .din_i  (grant),
    .head_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule
